uart_tx_frame: RTL and testbench

//   Configurable UART transmitter: AXIS slave byte stream in, serial TXD out.

---
 rtl/uart_tx_frame.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one byte per AXIS beat and serialises it as
// start / data (LSB first) / optional parity / stop bits, with hold and BREAK.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT      = 16,
  parameter int DATA_BITS         = 8,
  parameter int PARITY            = 0,
  parameter int STOP_BITS         = 1,
  parameter int G_AXIS_TDATA_SIZE = 8
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic                         i_s_axis_tvalid,
  output logic                         o_s_axis_tready,
  input  logic [G_AXIS_TDATA_SIZE-1:0] i_s_axis_tdata,
  input  logic                         i_s_axis_thold,
  input  logic                         i_break,
  output logic                         o_txd,
  output logic                         o_txd_busy,
  output logic                         o_txd_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = 3;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK,
    S_BRK_MARK
  } state_e;

  state_e                 state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   txd_q;
  logic                   done_q;
  logic                   rdy_en_q;

  logic bit_end;
  logic stop_last;
  logic accept;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign stop_last = (state_q == S_STOP) && (idx_q == STOP_LAST) && bit_end;

  // NOTE: tready is a deliberate combinational path from thold/break so a
  // beat can be taken on the final stop cycle; rdy_en_q keeps it low for the
  // first cycle after reset release.
  assign o_s_axis_tready = rdy_en_q && !i_s_axis_thold && !i_break &&
                           ((state_q == S_IDLE) || stop_last);
  assign accept          = i_s_axis_tvalid && o_s_axis_tready;

  assign o_txd      = txd_q;
  assign o_txd_busy = (state_q != S_IDLE);
  assign o_txd_done = done_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; later assignments in the case override the defaults.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      // Look one cycle ahead so the done pulse lands on the last stop cycle.
      done_q   <= (state_q == S_STOP) && (idx_q == STOP_LAST) && (baud_q == BAUD_PRE);
      baud_q   <= bit_end ? '0 : baud_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          idx_q  <= '0;
          if (i_break) begin
            state_q <= S_BREAK;
            txd_q   <= 1'b0;
          end else if (accept) begin
            state_q <= S_START;
            txd_q   <= 1'b0;
            shift_q <= i_s_axis_tdata[DATA_BITS-1:0];
          end
        end

        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            idx_q   <= '0;
            txd_q   <= shift_q[0];
            par_q   <= (PARITY == 1) ? ~(^shift_q) : (^shift_q);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (PARITY != 0) begin
                state_q <= S_PARITY;
                txd_q   <= par_q;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              idx_q   <= idx_q + 1'b1;
              txd_q   <= shift_q[1];
              shift_q <= shift_q >> 1;
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            idx_q   <= '0;
            txd_q   <= 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (idx_q == STOP_LAST) begin
              idx_q <= '0;
              if (accept) begin
                state_q <= S_START;
                txd_q   <= 1'b0;
                shift_q <= i_s_axis_tdata[DATA_BITS-1:0];
              end else begin
                state_q <= S_IDLE;
                txd_q   <= 1'b1;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        S_BREAK: begin
          baud_q <= '0;
          idx_q  <= '0;
          if (!i_break) begin
            state_q <= S_BRK_MARK;
            txd_q   <= 1'b1;
          end
        end

        S_BRK_MARK: begin
          if (bit_end) begin
            if (idx_q == STOP_LAST) begin
              state_q <= S_IDLE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three instances (no parity, even, odd)
// share clock, reset, data, hold and break; each has its own tvalid.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       thold = 1'b0;
  logic       brk = 1'b0;
  logic [2:0] vld = 3'b000;
  wire  [2:0] rdy;
  wire  [2:0] txd;
  wire  [2:0] busy;
  wire  [2:0] done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .G_AXIS_TDATA_SIZE(8)) u_dut_none (
    .i_clk(clk), .i_arst_n(rst_n), .i_s_axis_tvalid(vld[0]), .o_s_axis_tready(rdy[0]),
    .i_s_axis_tdata(tdata), .i_s_axis_thold(thold), .i_break(brk),
    .o_txd(txd[0]), .o_txd_busy(busy[0]), .o_txd_done(done[0]));

  uart_tx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                  .G_AXIS_TDATA_SIZE(8)) u_dut_even (
    .i_clk(clk), .i_arst_n(rst_n), .i_s_axis_tvalid(vld[1]), .o_s_axis_tready(rdy[1]),
    .i_s_axis_tdata(tdata), .i_s_axis_thold(thold), .i_break(brk),
    .o_txd(txd[1]), .o_txd_busy(busy[1]), .o_txd_done(done[1]));

  uart_tx_frame #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .G_AXIS_TDATA_SIZE(8)) u_dut_odd (
    .i_clk(clk), .i_arst_n(rst_n), .i_s_axis_tvalid(vld[2]), .o_s_axis_tready(rdy[2]),
    .i_s_axis_tdata(tdata), .i_s_axis_thold(thold), .i_break(brk),
    .o_txd(txd[2]), .o_txd_busy(busy[2]), .o_txd_done(done[2]));

  // Present one beat, wait (bounded) for tready, return just after the accepting edge.
  task automatic accept_beat(input int sel, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    tdata = d;
    vld[sel] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (rdy[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    vld[sel] = 1'b0;
  endtask

  // Sample one frame at every negedge: each bit must be steady for 16 cycles,
  // busy high throughout, and done only on the final cycle.
  task automatic capture(input int sel, input int nbits, output logic [15:0] bits,
                         output int bad, output int dones);
    bits = '0;
    bad = 0;
    dones = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        if (c == 0) bits[b] = txd[sel];
        else if (txd[sel] !== bits[b]) bad++;
        if (busy[sel] !== 1'b1) bad++;
        if (done[sel] === 1'b1) begin
          dones++;
          if (!(b == nbits - 1 && c == 15)) bad++;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (txd !== 3'b111) begin n_fail++; $display("FAIL reset_txd: got %b expected 111", txd); end
    n_tests++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset_tready: got %b expected 000", rdy); end
    n_tests++; if (busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy: got %b expected 000", busy); end
    n_tests++; if (done !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b expected 000", done); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (rdy !== 3'b000) begin n_fail++; $display("FAIL first_cycle_tready: got %b expected 000", rdy); end
    @(negedge clk);
    #1;
    n_tests++; if (rdy !== 3'b111) begin n_fail++; $display("FAIL idle_tready: got %b expected 111", rdy); end
  endtask

  task automatic test_basic();
    bit ok; logic [15:0] bits; int bad, dones;
    accept_beat(0, 8'h55, ok);
    capture(0, 10, bits, bad, dones);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_accept: got %b expected 1", ok); end
    n_tests++; if (bits[9:0] !== 10'h2AA) begin n_fail++; $display("FAIL basic_bits: got %h expected 2aa", bits[9:0]); end
    n_tests++; if (bits[8:1] !== 8'h55) begin n_fail++; $display("FAIL basic_rx_byte: got %h expected 55", bits[8:1]); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL basic_timing: got %0d errors expected 0", bad); end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses expected 1", dones); end
    @(negedge clk);
    n_tests++; if ({busy[0], txd[0]} !== 2'b01) begin n_fail++; $display("FAIL basic_len160: got busy,txd=%b expected 01", {busy[0], txd[0]}); end
  endtask

  task automatic test_parity();
    bit ok; logic [15:0] bits; int bad, dones;
    accept_beat(1, 8'h07, ok);
    capture(1, 11, bits, bad, dones);
    n_tests++; if (bits[10:0] !== 11'h60E || !ok) begin n_fail++; $display("FAIL even_bits: got %h expected 60e", bits[10:0]); end
    n_tests++; if (bad != 0 || dones != 1) begin n_fail++; $display("FAIL even_timing: got %0d errors %0d dones expected 0 1", bad, dones); end
    @(negedge clk);
    n_tests++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL even_len176: got busy %b expected 0", busy[1]); end
    accept_beat(2, 8'h07, ok);
    capture(2, 11, bits, bad, dones);
    n_tests++; if (bits[10:0] !== 11'h40E || !ok) begin n_fail++; $display("FAIL odd_bits: got %h expected 40e", bits[10:0]); end
    n_tests++; if (bad != 0 || dones != 1) begin n_fail++; $display("FAIL odd_timing: got %0d errors %0d dones expected 0 1", bad, dones); end
    @(negedge clk);
    n_tests++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL odd_len176: got busy %b expected 0", busy[2]); end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [15:0] b1, b2; int bad1, bad2, d1, d2;
    ok = 1'b0;
    tdata = 8'hA5;
    vld[0] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (rdy[0] === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    tdata = 8'h3C;
    capture(0, 10, b1, bad1, d1);
    n_tests++; if (rdy[0] !== 1'b1 || !ok) begin n_fail++; $display("FAIL b2b_ready_at_stop: got %b expected 1", rdy[0]); end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    capture(0, 10, b2, bad2, d2);
    n_tests++; if (b1[9:0] !== 10'h34A) begin n_fail++; $display("FAIL b2b_first: got %h expected 34a", b1[9:0]); end
    n_tests++; if (b2[9:0] !== 10'h278) begin n_fail++; $display("FAIL b2b_second: got %h expected 278", b2[9:0]); end
    n_tests++; if (bad1 + bad2 != 0 || d1 != 1 || d2 != 1) begin n_fail++; $display("FAIL b2b_timing: got %0d errors %0d/%0d dones expected 0 1/1", bad1 + bad2, d1, d2); end
    @(negedge clk);
    n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_end_idle: got busy %b expected 0", busy[0]); end
  endtask

  task automatic test_thold();
    logic [15:0] bits; int bad, dones, held;
    held = 0;
    thold = 1'b1;
    tdata = 8'h3C;
    vld[0] = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rdy[0] !== 1'b0 || txd[0] !== 1'b1 || busy[0] !== 1'b0) held++;
    end
    n_tests++; if (held != 0) begin n_fail++; $display("FAIL thold_block: got %0d bad cycles expected 0", held); end
    thold = 1'b0;
    #1;
    n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL thold_release_ready: got %b expected 1", rdy[0]); end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    capture(0, 10, bits, bad, dones);
    n_tests++; if (bits[9:0] !== 10'h278 || bad != 0 || dones != 1) begin n_fail++; $display("FAIL thold_frame: got %h/%0d/%0d expected 278/0/1", bits[9:0], bad, dones); end
  endtask

  task automatic test_reset_mid();
    bit ok; logic [15:0] bits; int bad, dones;
    @(negedge clk);
    accept_beat(0, 8'hF0, ok);
    repeat (3 * 16 + 5) @(negedge clk);
    n_tests++; if (busy[0] !== 1'b1 || !ok) begin n_fail++; $display("FAIL midreset_pre_busy: got %b expected 1", busy[0]); end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({txd[0], busy[0]} !== 2'b10) begin n_fail++; $display("FAIL midreset_abort: got txd,busy=%b expected 10", {txd[0], busy[0]}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    accept_beat(0, 8'h81, ok);
    capture(0, 10, bits, bad, dones);
    n_tests++; if (bits[9:0] !== 10'h302 || bad != 0 || dones != 1 || !ok) begin n_fail++; $display("FAIL midreset_recover: got %h/%0d/%0d expected 302/0/1", bits[9:0], bad, dones); end
  endtask

  task automatic test_break();
    bit ok; logic [15:0] bits; int bad, dones, lowbad, markbad;
    lowbad = 0;
    markbad = 0;
    @(negedge clk);
    brk = 1'b1;
    tdata = 8'hEE;
    vld[0] = 1'b1;
    #1;
    n_tests++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL break_wins_ready: got %b expected 0", rdy[0]); end
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b0 || busy[0] !== 1'b1) lowbad++;
    end
    brk = 1'b0;
    n_tests++; if (lowbad != 0) begin n_fail++; $display("FAIL break_low300: got %0d bad cycles expected 0", lowbad); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || rdy[0] !== 1'b0 || busy[0] !== 1'b1) markbad++;
    end
    n_tests++; if (markbad != 0) begin n_fail++; $display("FAIL break_mark16: got %0d bad cycles expected 0", markbad); end
    @(negedge clk);
    n_tests++; if ({rdy[0], busy[0]} !== 2'b10) begin n_fail++; $display("FAIL break_idle: got rdy,busy=%b expected 10", {rdy[0], busy[0]}); end
    // A break raised while a frame is in flight waits for the stop bit.
    accept_beat(0, 8'h55, ok);
    brk = 1'b1;
    capture(0, 10, bits, bad, dones);
    n_tests++; if (bits[9:0] !== 10'h2AA || bad != 0 || dones != 1 || !ok) begin n_fail++; $display("FAIL break_deferred_frame: got %h/%0d/%0d expected 2aa/0/1", bits[9:0], bad, dones); end
    @(negedge clk);
    n_tests++; if (txd[0] !== 1'b1) begin n_fail++; $display("FAIL break_deferred_idle: got %b expected 1", txd[0]); end
    @(negedge clk);
    n_tests++; if (txd[0] !== 1'b0) begin n_fail++; $display("FAIL break_deferred_low: got %b expected 0", txd[0]); end
    brk = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL break_deferred_ready: got %b expected 1", rdy[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_thold();
    test_reset_mid();
    test_break();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
